// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity-type codes and line levels.
// The parity codes are common to the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Counter width for a count of n states, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_parity_gen.sv
// Combinational parity of the latched transmit word.
// Even type gives the XOR of the bits, odd type its complement.
module uart_tx_parity_gen
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             par_typ_i,
    output logic             par_o
);

    // Select even or odd parity of the word.
    always_comb begin
        par_o = (par_typ_i == PAR_EVEN) ? (^data_i) : (~^data_i);
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
// Each bit lasts PRESCALE clocks. TX_OUT and BUSY come straight from flops.
// Build option: define UART_TX_PARITY_EN to include the parity bit; otherwise
// PAR_EN and PAR_TYP are accepted but ignored.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic             TX_OUT,
    output logic             BUSY
);

    localparam int unsigned CW = cnt_width(PRESCALE);
    localparam int unsigned IW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    tx_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic [WIDTH-1:0] data_q;
    logic             tx_q;
    logic             busy_q;
    logic             bit_end;
    logic             next_bit;

`ifdef UART_TX_PARITY_EN
    logic             par_en_q;
    logic             par_typ_q;
    logic             par_bit;

    uart_tx_parity_gen #(
        .WIDTH (WIDTH)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_o     (par_bit)
    );
`else
    logic             unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Bit-boundary detection and next values of the prescale counter and bit index.
    always_comb begin
        bit_end  = (cnt_q == CNT_LAST);
        cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q + 1'b1;
        next_bit = data_q[idx_d];
    end

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= LINE_IDLE;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
`endif
                        state_q   <= START;
                        tx_q      <= START_BIT;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= data_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_q <= PARITY;
                                tx_q    <= par_bit;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= LINE_IDLE;
                            end
`else
                            state_q <= STOP;
                            tx_q    <= LINE_IDLE;
`endif
                        end else begin
                            idx_q <= idx_d;
                            tx_q  <= next_bit;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q <= IDLE;
                        tx_q    <= LINE_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tx_q    <= LINE_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule
